// File: rtl/byte_mem_word_port_pkg.sv
// Shared definitions for the byte-organised memory word port: FSM encoding and byte-lane mapping.
package byte_mem_word_port_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StXfer,
    StResp
  } state_e;

  // Word byte lane that holds the i-th byte in address order.
  function automatic int unsigned lane(input int unsigned i, input int unsigned word_bytes,
                                       input bit big_endian);
    return big_endian ? (word_bytes - 1 - i) : i;
  endfunction

endpackage

// File: rtl/byte_mem_word_port_ram.sv
// DEPTH x 8 byte storage: synchronous write, combinational read, contents not reset.
module byte_mem_word_port_ram #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned AW     = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/byte_mem_word_port.sv
// Word-wide valid/ready port onto byte storage; moves one byte per cycle, reports range errors.
module byte_mem_word_port
  import byte_mem_word_port_pkg::*;
#(
  parameter int unsigned ADDR_W     = 27,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned WORD_BYTES = 4,
  parameter bit          BIG_ENDIAN = 1'b1,
  localparam int unsigned WORD_W    = 8 * WORD_BYTES
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [WORD_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [WORD_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam int unsigned RamAw = $clog2(DEPTH);
  localparam int unsigned CntW  = $clog2(WORD_BYTES) + 1;
  localparam int unsigned LaneW = $clog2(WORD_BYTES);

  state_e            state_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic [WORD_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic [CntW-1:0]   cnt_q;
  logic              we_q;
  logic [RamAw-1:0]  addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] asm_q, asm_d;

  logic [ADDR_W:0]   req_end;
  logic              range_err;
  logic [LaneW-1:0]  lane_sel;
  logic              last_byte;
  logic              ram_we;
  logic [RamAw-1:0]  ram_addr;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;

  // One extra bit so that addresses near the top of the address space cannot wrap.
  always_comb begin
    req_end   = {1'b0, req_addr_i} + (ADDR_W + 1)'(WORD_BYTES);
    range_err = req_end > (ADDR_W + 1)'(DEPTH);
  end

  always_comb begin
    lane_sel  = LaneW'(lane(32'(cnt_q), WORD_BYTES, BIG_ENDIAN));
    last_byte = cnt_q == CntW'(WORD_BYTES - 1);
    ram_addr  = addr_q + RamAw'(cnt_q);
    ram_we    = (state_q == StXfer) && we_q;
    ram_wdata = wdata_q[{lane_sel, 3'b000} +: 8];
    asm_d     = asm_q;
    if ((state_q == StXfer) && !we_q) begin
      asm_d[{lane_sel, 3'b000} +: 8] = ram_rdata;
    end
  end

  byte_mem_word_port_ram #(
    .DEPTH (DEPTH),
    .AW    (RamAw)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      asm_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            we_q        <= req_we_i;
            addr_q      <= req_addr_i[RamAw-1:0];
            wdata_q     <= req_wdata_i;
            asm_q       <= '0;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            if (range_err) begin
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q <= StXfer;
            end
          end
        end
        StXfer: begin
          asm_q <= asm_d;
          if (last_byte) begin
            state_q     <= StResp;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= we_q ? '0 : asm_d;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StResp: begin
          if (rsp_ready_i) begin
            state_q     <= StIdle;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
          end
        end
        default: begin
          state_q     <= StIdle;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_byte_mem_word_port.sv
// Self-checking bench for byte_mem_word_port against a byte-array reference model.
module tb_byte_mem_word_port;

  localparam int unsigned ADDR_W     = 27;
  localparam int unsigned DEPTH      = 256;
  localparam int unsigned WORD_BYTES = 4;
  localparam bit          BIG_ENDIAN = 1'b1;
  localparam int unsigned WORD_W     = 8 * WORD_BYTES;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_rdata;
  logic              rsp_err;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] model_mem [DEPTH];

  always #5 clk = ~clk;

  byte_mem_word_port #(
    .ADDR_W     (ADDR_W),
    .DEPTH      (DEPTH),
    .WORD_BYTES (WORD_BYTES),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word as seen from address a: big-endian puts the first byte at the top.
  function automatic logic [WORD_W-1:0] model_read(input int unsigned a);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int i = 0; i < int'(WORD_BYTES); i++) begin
      if (BIG_ENDIAN) w = (w << 8) | WORD_W'(model_mem[a + i]);
      else            w = w | (WORD_W'(model_mem[a + i]) << (8 * i));
    end
    return w;
  endfunction

  task automatic model_write(input int unsigned a, input logic [WORD_W-1:0] d, input int nbytes);
    logic [WORD_W-1:0] sh;
    for (int i = 0; i < nbytes; i++) begin
      sh = BIG_ENDIAN ? (d >> (8 * (int'(WORD_BYTES) - 1 - i))) : (d >> (8 * i));
      model_mem[a + i] = sh[7:0];
    end
  endtask

  function automatic bit model_err(input logic [ADDR_W-1:0] a);
    return (longint'(a) + longint'(WORD_BYTES)) > longint'(DEPTH);
  endfunction

  // One full transaction; hold > 0 stalls the response and pokes req_valid meanwhile.
  task automatic transact(input bit we, input logic [ADDR_W-1:0] addr,
                          input logic [WORD_W-1:0] wd, input int hold, input string tag);
    bit                exp_err;
    logic [WORD_W-1:0] exp_rd;
    int                lat;
    int                n;
    exp_err = model_err(addr);
    exp_rd  = (we || exp_err) ? '0 : model_read(int'(addr));
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " accept"}, 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = ADDR_W'($urandom);
    req_wdata = WORD_W'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 64'(lat), exp_err ? 64'd1 : 64'(WORD_BYTES + 1));
    check({tag, " err"}, 64'(rsp_err), 64'(exp_err));
    check({tag, " rdata"}, 64'(rsp_rdata), 64'(exp_rd));
    check({tag, " ready in resp"}, 64'(req_ready), 64'd0);
    for (int h = 0; h < hold; h++) begin
      if (h == 1) begin
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = '0;
        req_wdata = ~model_read(0);
      end else begin
        req_valid = 1'b0;
      end
      @(posedge clk); #1;
      check({tag, " hold valid"}, 64'(rsp_valid), 64'd1);
      check({tag, " hold rdata"}, 64'(rsp_rdata), 64'(exp_rd));
      check({tag, " hold err"}, 64'(rsp_err), 64'(exp_err));
      check({tag, " hold ready"}, 64'(req_ready), 64'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, " done valid"}, 64'(rsp_valid), 64'd0);
    check({tag, " done ready"}, 64'(req_ready), 64'd1);
    if (we && !exp_err) model_write(int'(addr), wd, int'(WORD_BYTES));
  endtask

  initial begin
    int unsigned       bb_addr [4];
    logic [WORD_W-1:0] bb_exp  [4];
    int                k, r, cyc, last, first_acc;
    bit                acc;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset req_ready", 64'(req_ready), 64'd1);
    check("reset rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("reset rsp_err", 64'(rsp_err), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill the whole array so every later read has a known expectation.
    for (int unsigned a = 0; a < DEPTH; a += WORD_BYTES)
      transact(1'b1, ADDR_W'(a), WORD_W'($urandom), 0, "fill");

    transact(1'b1, 22, 32'h11223344, 0, "wr22");
    transact(1'b0, 22, '0, 0, "rd22");
    transact(1'b1, 26, 32'hAABBCCDD, 0, "wr26");
    transact(1'b0, 24, '0, 0, "rd24");

    transact(1'b0, ADDR_W'(DEPTH - WORD_BYTES), '0, 0, "rd top legal");
    transact(1'b0, ADDR_W'(DEPTH - WORD_BYTES + 1), '0, 0, "rd top err");
    transact(1'b1, ADDR_W'(DEPTH - WORD_BYTES + 1), 32'hCAFEF00D, 0, "wr top err");
    transact(1'b0, ADDR_W'(DEPTH - WORD_BYTES), '0, 0, "rd top after err");
    transact(1'b0, {ADDR_W{1'b1}} - ADDR_W'(1), '0, 0, "rd wrap err");

    transact(1'b0, 22, '0, 3, "stall");
    transact(1'b0, 0, '0, 0, "rd0 after stall");

    // Abort a write after two bytes have been committed.
    check("abort pre ready", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 40;
    req_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort rsp_valid", 64'(rsp_valid), 64'd0);
    check("abort rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("abort rsp_err", 64'(rsp_err), 64'd0);
    model_write(40, 32'hDEADBEEF, 2);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort ready after release", 64'(req_ready), 64'd1);
    check("abort no response", 64'(rsp_valid), 64'd0);
    transact(1'b0, 40, '0, 0, "rd40 after abort");

    for (int t = 0; t < 40; t++) begin
      logic [ADDR_W-1:0] a;
      a = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom)
                                      : ADDR_W'($urandom_range(0, DEPTH + WORD_BYTES));
      transact(1'($urandom), a, WORD_W'($urandom), 0, "random");
    end

    // Back-to-back reads with both handshakes tied high.
    for (int i = 0; i < 4; i++) begin
      bb_addr[i] = $urandom_range(0, DEPTH - WORD_BYTES);
      bb_exp[i]  = model_read(bb_addr[i]);
    end
    k = 0; r = 0; cyc = 0; last = 0; first_acc = 0;
    req_we    = 1'b0;
    req_addr  = ADDR_W'(bb_addr[0]);
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    while (r < 4 && cyc < 200) begin
      acc = req_ready && req_valid;
      if (rsp_valid) begin
        check("b2b rdata", 64'(rsp_rdata), 64'(bb_exp[r]));
        check("b2b err", 64'(rsp_err), 64'd0);
        if (r == 0) check("b2b first latency", 64'(cyc - first_acc), 64'(WORD_BYTES + 1));
        else        check("b2b period", 64'(cyc - last), 64'(WORD_BYTES + 2));
        last = cyc;
        r++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        if (k == 0) first_acc = cyc - 1;
        k++;
        if (k < 4) req_addr = ADDR_W'(bb_addr[k]);
        else       req_valid = 1'b0;
      end
    end
    check("b2b response count", 64'(r), 64'd4);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
